// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants and types for the PS/2 keyboard event receiver.
//   - event word bit positions
//   - Set 2 prefix bytes and modifier scan codes
//   - prefix FSM state encoding and modifier state record
//   - odd-parity helper for frame validation
package ps2_pkg;

  localparam int EV_BRK   = 15;
  localparam int EV_EXT   = 14;
  localparam int EV_SHIFT = 13;
  localparam int EV_CTRL  = 12;
  localparam int EV_ALT   = 11;
  localparam int EV_CAPS  = 10;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;  // right ctrl is E0 14
  localparam logic [7:0] SC_ALT    = 8'h11;  // right alt is E0 11
  localparam logic [7:0] SC_CAPS   = 8'h58;

  typedef enum logic [1:0] {
    PFX_IDLE,
    PFX_EXT,
    PFX_BRK,
    PFX_EXT_BRK
  } pfx_state_t;

  typedef struct packed {
    logic lshift;
    logic rshift;
    logic lctrl;
    logic rctrl;
    logic lalt;
    logic ralt;
    logic caps;
  } mod_t;

  // Data bits plus parity bit must contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: generic synchronous show-ahead FIFO.
//   clk, rst        : clock, synchronous active-high reset (pointers/count only)
//   push, din       : write request and data; ignored when full unless popping
//   pop             : read request; ignored when empty
//   dout            : head entry, forced to 0 while empty
//   empty, full     : occupancy flags
//   level           : current occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module ps2_event_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push & (~full | pop);
  assign level   = count;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ps2_key_event_rx.sv
// ps2_key_event_rx: PS/2 device-to-host receiver with Set 2 prefix resolution,
// modifier tracking and a show-ahead event FIFO.
//   clk, rst         : system clock, synchronous active-high reset
//   ps2_clk_async    : raw PS/2 clock pin
//   ps2_data_async   : raw PS/2 data pin
//   ev_data          : head event {break, ext, shift, ctrl, alt, caps, 2'b0, scan}
//   ev_valid         : FIFO non-empty
//   ev_ready         : consumer pop strobe
//   fifo_level       : FIFO occupancy
//   overflow         : sticky, an event was dropped on a full FIFO
//   err_cnt          : saturating count of bad frames and timeouts
//   stat_clr         : clears overflow and err_cnt
// Optional build macro PS2_TYPEMATIC_FILTER_EN: suppresses auto-repeat makes of
// keys already held down (FIFO only; modifier state still updates).
module ps2_key_event_rx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int TIMEOUT_US = 2600,
  parameter int FIFO_DEPTH = 16,
  parameter int ERR_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk_async,
  input  logic                          ps2_data_async,
  output logic [15:0]                   ev_data,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [ERR_W-1:0]              err_cnt,
  input  logic                          stat_clr
);

  localparam int TIMEOUT_CYC = CLK_HZ / 1000000 * TIMEOUT_US;
  localparam int TMO_W       = $clog2(TIMEOUT_CYC + 1);

  logic clk_r0, clk_r1, dat_r0, dat_r1;
  logic fall;
  logic [3:0] bit_cnt;
  logic [9:0] sr;
  logic [TMO_W-1:0] tmo_cnt;
  logic frame_ok, timeout, err_inc;
  logic [7:0] byte_p1;
  logic vld_p1;
  pfx_state_t pfx_q, pfx_nxt;
  logic emit, ev_brk, ev_ext, push_n;
  mod_t mod_q, mod_n;
  logic [15:0] ev_word, ev_p2;
  logic vld_p2;
  logic fifo_empty, fifo_full;

  // p0: pin synchronisers (idle-high bus, so they reset to 1)
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_r0 <= 1'b1;
      clk_r1 <= 1'b1;
      dat_r0 <= 1'b1;
      dat_r1 <= 1'b1;
    end else begin
      clk_r0 <= ps2_clk_async;
      clk_r1 <= clk_r0;
      dat_r0 <= ps2_data_async;
      dat_r1 <= dat_r0;
    end
  end

  // Data is sampled from the older flop: the device settles it while the
  // PS/2 clock is still high, well before the falling edge is seen.
  assign fall     = clk_r1 & ~clk_r0;
  assign frame_ok = ~sr[0] & dat_r1 & odd_parity_ok(sr[9:1]);
  assign timeout  = (bit_cnt != 4'd0) && !fall &&
                    (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
  assign err_inc  = (fall && bit_cnt == 4'd10 && !frame_ok) || timeout;

  // p1: frame deserialiser; byte_p1/vld_p1 hold the decided byte
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= 4'd0;
      tmo_cnt <= '0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (fall) begin
        tmo_cnt <= '0;
        if (bit_cnt == 4'd0) begin
          if (!dat_r1) bit_cnt <= 4'd1;
        end else if (bit_cnt == 4'd10) begin
          bit_cnt <= 4'd0;
          vld_p1  <= frame_ok;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != 4'd0) begin
        if (timeout) begin
          bit_cnt <= 4'd0;
          tmo_cnt <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end
    end
  end

  // After ten shifts sr holds {parity, data[7:0], start}; older bits fall out.
  always_ff @(posedge clk) begin
    if (fall && bit_cnt != 4'd10) sr <= {dat_r1, sr[9:1]};
    if (fall && bit_cnt == 4'd10) byte_p1 <= sr[8:1];
  end

  always_ff @(posedge clk) begin
    if (rst || stat_clr) err_cnt <= '0;
    else if (err_inc && err_cnt != {ERR_W{1'b1}}) err_cnt <= err_cnt + 1'b1;
  end

  // Prefix FSM: state register
  always_ff @(posedge clk) begin
    if (rst) pfx_q <= PFX_IDLE;
    else     pfx_q <= pfx_nxt;
  end

  // Prefix FSM: next state
  always_comb begin
    pfx_nxt = pfx_q;
    if (vld_p1) begin
      unique case (pfx_q)
        PFX_IDLE: begin
          if (byte_p1 == PS2_PFX_EXT)      pfx_nxt = PFX_EXT;
          else if (byte_p1 == PS2_PFX_BRK) pfx_nxt = PFX_BRK;
          else                             pfx_nxt = PFX_IDLE;
        end
        PFX_EXT: begin
          if (byte_p1 == PS2_PFX_BRK)      pfx_nxt = PFX_EXT_BRK;
          else if (byte_p1 == PS2_PFX_EXT) pfx_nxt = PFX_EXT;
          else                             pfx_nxt = PFX_IDLE;
        end
        default:                           pfx_nxt = PFX_IDLE;
      endcase
    end
  end

  // Prefix FSM: outputs. A prefix byte in a break state abandons the sequence.
  always_comb begin
    emit   = vld_p1 && byte_p1 != PS2_PFX_EXT && byte_p1 != PS2_PFX_BRK;
    ev_brk = (pfx_q == PFX_BRK) || (pfx_q == PFX_EXT_BRK);
    ev_ext = (pfx_q == PFX_EXT) || (pfx_q == PFX_EXT_BRK);
  end

  always_comb begin
    mod_n = mod_q;
    if (emit) begin
      case ({ev_ext, byte_p1})
        {1'b0, SC_LSHIFT}: mod_n.lshift = ~ev_brk;
        {1'b0, SC_RSHIFT}: mod_n.rshift = ~ev_brk;
        {1'b0, SC_CTRL}:   mod_n.lctrl  = ~ev_brk;
        {1'b1, SC_CTRL}:   mod_n.rctrl  = ~ev_brk;
        {1'b0, SC_ALT}:    mod_n.lalt   = ~ev_brk;
        {1'b1, SC_ALT}:    mod_n.ralt   = ~ev_brk;
        {1'b0, SC_CAPS}:   if (!ev_brk) mod_n.caps = ~mod_q.caps;
        default:           mod_n = mod_q;
      endcase
    end
  end

  // Snapshot reflects modifier state after this event has been applied.
  always_comb begin
    ev_word           = {8'h00, byte_p1};
    ev_word[EV_BRK]   = ev_brk;
    ev_word[EV_EXT]   = ev_ext;
    ev_word[EV_SHIFT] = mod_n.lshift | mod_n.rshift;
    ev_word[EV_CTRL]  = mod_n.lctrl | mod_n.rctrl;
    ev_word[EV_ALT]   = mod_n.lalt | mod_n.ralt;
    ev_word[EV_CAPS]  = mod_n.caps;
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [511:0] key_down;
  logic [8:0]   key_idx;

  assign key_idx = {ev_ext, byte_p1};
  assign push_n  = emit & ~(~ev_brk & key_down[key_idx]);

  always_ff @(posedge clk) begin
    if (rst)       key_down <= '0;
    else if (emit) key_down[key_idx] <= ~ev_brk;
  end
`else
  assign push_n = emit;
`endif

  // p2: registered event and modifier state, written to the FIFO next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2 <= 1'b0;
      mod_q  <= '0;
    end else begin
      vld_p2 <= push_n;
      mod_q  <= mod_n;
    end
  end

  always_ff @(posedge clk) begin
    ev_p2 <= ev_word;
  end

  ps2_event_fifo #(
    .WIDTH (16),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (vld_p2),
    .din   (ev_p2),
    .pop   (ev_ready),
    .dout  (ev_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level)
  );

  assign ev_valid = ~fifo_empty;

  always_ff @(posedge clk) begin
    if (rst || stat_clr)                    overflow <= 1'b0;
    else if (vld_p2 && fifo_full && !ev_ready) overflow <= 1'b1;
  end

endmodule

// File: doc/ps2_key_event_rx.md
Name: ps2_key_event_rx

Overview:
- Parametrised successor to the single-register PS/2 scan-code decoder.
- Deserialises PS/2 device-to-host frames and resolves Set 2 prefixes (E0, F0, E0 F0) into one event word per key action.
- Each event carries modifier snapshots and is buffered in a show-ahead FIFO with a valid/ready handshake.
- Sits between the board PS/2 pins and the CPU keyboard MMIO register; the CPU drains events at its own pace without losing keystrokes.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- TIMEOUT_US, 2600, inter-edge timeout in microseconds. TIMEOUT_CYC = CLK_HZ/1000000*TIMEOUT_US.
- FIFO_DEPTH, 16, event FIFO entries; power of two, range 2..256.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ps2_clk_async  in  1  raw PS/2 clock pin
- ps2_data_async  in  1  raw PS/2 data pin
- ev_data  out  16  head event: [15]=break, [14]=extended, [13]=shift, [12]=ctrl, [11]=alt, [10]=caps_lock, [9:8]=0, [7:0]=scan code
- ev_valid  out  1  FIFO non-empty
- ev_ready  in  1  consumer pop; a pop occurs when ev_valid&&ev_ready
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
- overflow  out  1  sticky; set when an event is dropped because the FIFO is full
- err_cnt  out  ERR_W  saturating count of bad frames and timeouts
- stat_clr  in  1  clears overflow and err_cnt

Behaviour:
- Reset: every output is 0. Synchroniser flops reset to 1. Bit counter, prefix FSM, modifiers, caps_lock and FIFO are cleared.
- Synchroniser: two flops on each pin. A PS/2 falling edge is detected as r1=1, r0=0.
- Receiver:
  - Falling edge with bit_cnt=0: accepted as the start bit only if data=0; if data=1 it is ignored (resync).
  - Bits are shifted LSB first, 11 bits per frame.
  - At bit_cnt=10: the frame is valid when start=0, stop=1 and parity over data+parity bits is odd.
  - An invalid frame is discarded and increments err_cnt.
- Timeout: while bit_cnt!=0, a cycle counter runs and is reset on each falling edge. On reaching TIMEOUT_CYC, the partial frame is discarded, bit_cnt=0 and err_cnt increments.
- err_cnt saturates at all-ones. stat_clr has priority over a same-cycle increment.
- Prefix FSM states, applied to valid bytes only:
  - IDLE: E0->EXT, F0->BRK, other->emit(make, ext=0), back to IDLE.
  - EXT: F0->EXT_BRK, E0->EXT, other->emit(make, ext=1), back to IDLE.
  - BRK: other->emit(break, ext=0), back to IDLE. E0/F0 in BRK go to IDLE with no emit.
  - EXT_BRK: other->emit(break, ext=1), back to IDLE.
- Modifiers:
  - shift = L(12)|R(59); ctrl = L(14)|R(E0 14); alt = L(11)|R(E0 11). Each is set on make and cleared on break.
  - caps_lock toggles on make of 58.
  - The bits written into an event reflect state after applying that event.
- Latency: the valid byte is decided one cycle after the stop-bit edge detect; the FIFO is written on the next cycle. With an empty FIFO, ev_valid rises 3 cycles after the stop-bit edge detect. There is no bypass.
- FIFO:
  - Show-ahead: ev_data is valid whenever ev_valid=1.
  - Full with pop and push in the same cycle: both occur and the level is unchanged.
  - Full with push only: the event is dropped and overflow is set.
  - Empty with pop: ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset mid-frame: the partial frame is lost. Trailing bits are rejected by the start-bit rule or the timeout.

Optional Feature:
- Macro PS2_TYPEMATIC_FILTER_EN.
- When defined:
  - A 512-bit key-down map, indexed by {ext, scan}, suppresses a make event for a key already down (auto-repeat).
  - Break events clear the bit.
  - The filter applies to the FIFO only; modifier state still updates.
  - rst clears the map.
- When not defined: every make, including typematic repeats, is queued.

Decomposition:
- Package ps2_pkg holds:
  - event bit-position localparams;
  - prefix constants PS2_PFX_EXT=8'hE0 and PS2_PFX_BRK=8'hF0;
  - modifier scan codes (12, 59, 14, 11, 58);
  - the FSM state enum.
- Sub-module ps2_event_fifo: generic synchronous show-ahead FIFO with parameters WIDTH and DEPTH, plus full/empty/level outputs. It is instantiated once.
- Receiver, FSM and filter stay in the top level.

Test Plan:
- Send frame 1C, ev_ready=0 -> ev_valid rises 3 cycles after the stop edge; ev_data=16'h001C; fifo_level=1.
- Send E0 F0 74 -> exactly one event, ev_data=16'hC074; the E0 and F0 prefixes produce no event.
- Send 12, 1C, F0 12 -> events 16'h2012, 16'h201C, 16'h8012.
- Send 1C with a bad parity bit -> no event and err_cnt=1. Then stop the PS/2 clock after 5 bits -> after TIMEOUT_CYC, err_cnt=2; the next good frame 32 decodes as 16'h0032.
- With FIFO_DEPTH=4 and ev_ready=0, send 5 make codes -> fifo_level=4, overflow=1, and the fifth is dropped. Assert stat_clr -> overflow=0, err_cnt=0.
- With PS2_TYPEMATIC_FILTER_EN, send 1C 1C 1C F0 1C 1C -> events 001C, 801C, 001C only.
